// File: rtl/hs_source_sink_if.sv
// Valid/ready stream bundle for the hs_source_sink test endpoints.
// The master modport is the endpoint pair; the slave modport is the surrounding link or bench.
interface hs_source_sink_if #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 256
) ();
    localparam int CW = $clog2(DEPTH + 1);

    logic             start;
    logic             src_ready;
    logic             src_vaild;
    logic [WIDTH-1:0] src_data;
    logic             src_done;
    logic             dst_vaild;
    logic [WIDTH-1:0] dst_data;
    logic             dst_ready;
    logic             dst_done;
    logic [CW-1:0]    rx_count;
    logic [CW-1:0]    err_count;
    logic             err;

    modport master (
        input  start, src_ready, dst_vaild, dst_data,
        output src_vaild, src_data, src_done, dst_ready, dst_done,
               rx_count, err_count, err
    );

    modport slave (
        output start, src_ready, dst_vaild, dst_data,
        input  src_vaild, src_data, src_done, dst_ready, dst_done,
               rx_count, err_count, err
    );
endinterface

// File: rtl/hs_source_sink.sv
// Paired source/sink test endpoints for a valid/ready link: the source emits 0..DEPTH-1,
// the sink accepts under a rotating ready pattern and checks the same sequence.
module hs_source_sink #(
    parameter int         WIDTH     = 9,
    parameter int         DEPTH     = 256,
    parameter logic [3:0] READY_PAT = 4'b0111
) (
    input  logic               clk,
    input  logic               s_rst,
    hs_source_sink_if.master   bus
);
    localparam int            CW      = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] ERR_MAX = '1;

    logic [CW-1:0]    tx_cnt_q, tx_cnt_d;
    logic             src_vaild_q, src_vaild_d;
    logic [WIDTH-1:0] src_data_q, src_data_d;
    logic             src_done_q, src_done_d;
    logic [1:0]       slot_q, slot_d;
    logic             dst_ready_q, dst_ready_d;
    logic             dst_done_q, dst_done_d;
    logic [CW-1:0]    rx_count_q, rx_count_d;
    logic [CW-1:0]    err_count_q, err_count_d;
    logic             err_q, err_d;
    logic             src_beat;
    logic             dst_beat;

    assign src_beat = src_vaild_q & bus.src_ready;
    assign dst_beat = bus.dst_vaild & dst_ready_q & ~dst_done_q;

    always_comb begin
        tx_cnt_d    = tx_cnt_q;
        src_vaild_d = src_vaild_q;
        src_data_d  = src_data_q;
        src_done_d  = src_done_q;
        slot_d      = slot_q + 2'd1;
        dst_done_d  = dst_done_q;
        rx_count_d  = rx_count_q;
        err_count_d = err_count_q;
        err_d       = err_q;

        // A stalled word is frozen regardless of start; start only gates new launches.
        if (!src_vaild_q || bus.src_ready) begin
            if (bus.start && (tx_cnt_q < DEPTH_C)) begin
                src_vaild_d = 1'b1;
                src_data_d  = WIDTH'(tx_cnt_q);
                tx_cnt_d    = tx_cnt_q + 1'b1;
            end else begin
                src_vaild_d = 1'b0;
            end
        end
        if (src_beat && (tx_cnt_q == DEPTH_C)) begin
            src_done_d = 1'b1;
        end

        if (dst_beat) begin
            rx_count_d = rx_count_q + 1'b1;
            if (bus.dst_data != WIDTH'(rx_count_q)) begin
                err_d = 1'b1;
                if (err_count_q != ERR_MAX) begin
                    err_count_d = err_count_q + 1'b1;
                end
            end
            if (rx_count_q == DEPTH_C - 1'b1) begin
                dst_done_d = 1'b1;
            end
        end
        dst_ready_d = READY_PAT[slot_q] & ~dst_done_d;
    end

    always_ff @(posedge clk or negedge s_rst) begin
        if (!s_rst) begin
            tx_cnt_q    <= '0;
            src_vaild_q <= 1'b0;
            src_data_q  <= '0;
            src_done_q  <= 1'b0;
            slot_q      <= 2'd0;
            dst_ready_q <= 1'b0;
            dst_done_q  <= 1'b0;
            rx_count_q  <= '0;
            err_count_q <= '0;
            err_q       <= 1'b0;
        end else begin
            tx_cnt_q    <= tx_cnt_d;
            src_vaild_q <= src_vaild_d;
            src_data_q  <= src_data_d;
            src_done_q  <= src_done_d;
            slot_q      <= slot_d;
            dst_ready_q <= dst_ready_d;
            dst_done_q  <= dst_done_d;
            rx_count_q  <= rx_count_d;
            err_count_q <= err_count_d;
            err_q       <= err_d;
        end
    end

    assign bus.src_vaild = src_vaild_q;
    assign bus.src_data  = src_data_q;
    assign bus.src_done  = src_done_q;
    assign bus.dst_ready = dst_ready_q;
    assign bus.dst_done  = dst_done_q;
    assign bus.rx_count  = rx_count_q;
    assign bus.err_count = err_count_q;
    assign bus.err       = err_q;
endmodule

// File: tb/tb_hs_source_sink.sv
// Directed bench for hs_source_sink: two loopback instances, one always-ready (u0),
// one with the default 0111 ready pattern (u1).
module tb_hs_source_sink;
    localparam int WIDTH = 9;
    localparam int DEPTH = 256;

    logic clk = 1'b0;
    logic s_rst;
    logic start0 = 1'b0;
    logic start1 = 1'b0;
    logic corrupt_en = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #10 clk = ~clk;

    hs_source_sink_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) if0 ();
    hs_source_sink_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) if1 ();

    assign if0.start     = start0;
    assign if0.src_ready = if0.dst_ready;
    assign if0.dst_vaild = if0.src_vaild;
    assign if0.dst_data  = if0.src_data;

    // Word 5 gets bit 0 flipped on its way to the sink while corrupt_en is set.
    assign if1.start     = start1;
    assign if1.src_ready = if1.dst_ready;
    assign if1.dst_vaild = if1.src_vaild;
    assign if1.dst_data  = if1.src_data ^ {{(WIDTH-1){1'b0}}, (corrupt_en && if1.src_data == 9'd5)};

    hs_source_sink #(.WIDTH(WIDTH), .DEPTH(DEPTH), .READY_PAT(4'b1111)) u0 (
        .clk(clk), .s_rst(s_rst), .bus(if0)
    );
    hs_source_sink #(.WIDTH(WIDTH), .DEPTH(DEPTH), .READY_PAT(4'b0111)) u1 (
        .clk(clk), .s_rst(s_rst), .bus(if1)
    );

    task automatic do_reset();
        s_rst  = 1'b0;
        start1 = 1'b0;
        repeat (3) @(negedge clk);
        #5 s_rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        logic [3:0]  pat;
        logic [31:0] all1;
        logic [31:0] all0;
        pat   = 4'b0111;
        s_rst = 1'b1;
        #2 s_rst = 1'b0;
        #48;
        all1 = {if1.src_vaild, if1.src_data, if1.src_done, if1.dst_ready, if1.dst_done,
                if1.rx_count, if1.err_count, if1.err};
        all0 = {if0.src_vaild, if0.src_data, if0.src_done, if0.dst_ready, if0.dst_done,
                if0.rx_count, if0.err_count, if0.err};
        checks++;
        if (all1 !== 32'd0) begin
            errors++;
            $display("FAIL reset_u1_outputs got %h exp 0", all1);
        end
        checks++;
        if (all0 !== 32'd0) begin
            errors++;
            $display("FAIL reset_u0_outputs got %h exp 0", all0);
        end
        #55 s_rst = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            checks++;
            if (if1.dst_ready !== pat[i % 4]) begin
                errors++;
                $display("FAIL ready_pattern cycle %0d got %b exp %b", i, if1.dst_ready, pat[i % 4]);
            end
        end
        checks++;
        if (if0.dst_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_all_ones got %b exp 1", if0.dst_ready);
        end
    endtask

    task automatic test_loopback_full();
        @(negedge clk);
        checks++;
        if (if0.src_vaild !== 1'b0) begin
            errors++;
            $display("FAIL idle_before_start got %b exp 0", if0.src_vaild);
        end
        start0 = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clk);
            checks++;
            if (if0.src_vaild !== 1'b1 || if0.src_data !== WIDTH'(i) || if0.rx_count !== 9'(i)) begin
                errors++;
                $display("FAIL full_rate word %0d got v=%b d=%0d rx=%0d exp v=1 d=%0d rx=%0d",
                         i, if0.src_vaild, if0.src_data, if0.rx_count, i, i);
            end
        end
        @(negedge clk);
        checks++;
        if (if0.src_done !== 1'b1 || if0.dst_done !== 1'b1 || if0.src_vaild !== 1'b0 ||
            if0.rx_count !== 9'd256 || if0.err_count !== 9'd0 || if0.err !== 1'b0 ||
            if0.dst_ready !== 1'b0) begin
            errors++;
            $display("FAIL full_done got sd=%b dd=%b v=%b rx=%0d ec=%0d e=%b rdy=%b exp 1 1 0 256 0 0 0",
                     if0.src_done, if0.dst_done, if0.src_vaild, if0.rx_count, if0.err_count,
                     if0.err, if0.dst_ready);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (if0.src_vaild !== 1'b0 || if0.rx_count !== 9'd256) begin
            errors++;
            $display("FAIL full_after_done got v=%b rx=%0d exp 0 256", if0.src_vaild, if0.rx_count);
        end
        start0 = 1'b0;
    endtask

    task automatic test_backpressure();
        int               exp_w = 0;
        int               stalls = 0;
        int               cyc = 0;
        logic             pv = 1'b0;
        logic             pr = 1'b0;
        logic [WIDTH-1:0] pd = '0;
        @(negedge clk);
        start1 = 1'b1;
        while (cyc < 3000) begin
            @(negedge clk);
            cyc++;
            if (if1.dst_done === 1'b1) break;
            if (pv && !pr) begin
                stalls++;
                checks++;
                if (if1.src_vaild !== 1'b1 || if1.src_data !== pd) begin
                    errors++;
                    $display("FAIL bp_stall_hold got v=%b d=%0d exp v=1 d=%0d", if1.src_vaild, if1.src_data, pd);
                end
            end
            if (if1.src_vaild && if1.src_ready) begin
                checks++;
                if (if1.src_data !== WIDTH'(exp_w)) begin
                    errors++;
                    $display("FAIL bp_sequence got %0d exp %0d", if1.src_data, exp_w);
                end
                exp_w++;
            end
            pv = if1.src_vaild;
            pr = if1.src_ready;
            pd = if1.src_data;
        end
        checks++;
        if (if1.dst_done !== 1'b1 || exp_w != DEPTH || stalls == 0) begin
            errors++;
            $display("FAIL bp_completion got done=%b beats=%0d stalls=%0d exp done=1 beats=256 stalls>0",
                     if1.dst_done, exp_w, stalls);
        end
        checks++;
        if (if1.rx_count !== 9'd256 || if1.err !== 1'b0 || if1.err_count !== 9'd0) begin
            errors++;
            $display("FAIL bp_result got rx=%0d e=%b ec=%0d exp 256 0 0", if1.rx_count, if1.err, if1.err_count);
        end
        @(negedge clk);
        checks++;
        if (if1.src_done !== 1'b1) begin
            errors++;
            $display("FAIL bp_src_done got %b exp 1", if1.src_done);
        end
    endtask

    task automatic test_start_toggle();
        int               exp_w = 0;
        int               cyc = 0;
        logic             pv = 1'b0;
        logic             pr = 1'b0;
        logic [WIDTH-1:0] pd = '0;
        do_reset();
        fork
            begin
                start1 = 1'b1;
                #80  start1 = 1'b0;
                #80  start1 = 1'b1;
                #100 start1 = 1'b0;
                #100 start1 = 1'b1;
            end
            begin
                while (cyc < 3000) begin
                    @(negedge clk);
                    cyc++;
                    if (if1.dst_done === 1'b1) break;
                    if (pv && !pr) begin
                        checks++;
                        if (if1.src_vaild !== 1'b1 || if1.src_data !== pd) begin
                            errors++;
                            $display("FAIL toggle_stall_hold got v=%b d=%0d exp v=1 d=%0d",
                                     if1.src_vaild, if1.src_data, pd);
                        end
                    end
                    if (if1.src_vaild && if1.src_ready) begin
                        checks++;
                        if (if1.src_data !== WIDTH'(exp_w)) begin
                            errors++;
                            $display("FAIL toggle_sequence got %0d exp %0d", if1.src_data, exp_w);
                        end
                        exp_w++;
                    end
                    pv = if1.src_vaild;
                    pr = if1.src_ready;
                    pd = if1.src_data;
                end
            end
        join
        checks++;
        if (if1.dst_done !== 1'b1 || exp_w != DEPTH || if1.rx_count !== 9'd256 || if1.err !== 1'b0) begin
            errors++;
            $display("FAIL toggle_completion got done=%b beats=%0d rx=%0d e=%b exp 1 256 256 0",
                     if1.dst_done, exp_w, if1.rx_count, if1.err);
        end
    endtask

    task automatic test_corrupt();
        int cyc = 0;
        do_reset();
        corrupt_en = 1'b1;
        start1     = 1'b1;
        while (if1.dst_done !== 1'b1 && cyc < 3000) begin
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (if1.dst_done !== 1'b1 || if1.rx_count !== 9'd256) begin
            errors++;
            $display("FAIL corrupt_completion got done=%b rx=%0d exp 1 256", if1.dst_done, if1.rx_count);
        end
        checks++;
        if (if1.err !== 1'b1 || if1.err_count !== 9'd1) begin
            errors++;
            $display("FAIL corrupt_errors got e=%b ec=%0d exp 1 1", if1.err, if1.err_count);
        end
        corrupt_en = 1'b0;
    endtask

    task automatic test_reset_mid();
        int          cyc = 0;
        logic [31:0] all1;
        do_reset();
        start1 = 1'b1;
        while (!(if1.src_vaild === 1'b1 && if1.src_data === 9'd100) && cyc < 1000) begin
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (if1.src_vaild !== 1'b1 || if1.src_data !== 9'd100) begin
            errors++;
            $display("FAIL midreset_reach_word100 got v=%b d=%0d exp 1 100", if1.src_vaild, if1.src_data);
        end
        #2 s_rst = 1'b0;
        #1;
        all1 = {if1.src_vaild, if1.src_data, if1.src_done, if1.dst_ready, if1.dst_done,
                if1.rx_count, if1.err_count, if1.err};
        checks++;
        if (all1 !== 32'd0) begin
            errors++;
            $display("FAIL midreset_outputs got %h exp 0", all1);
        end
        repeat (2) @(negedge clk);
        #5 s_rst = 1'b1;
        cyc = 0;
        while (if1.src_vaild !== 1'b1 && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (if1.src_vaild !== 1'b1 || if1.src_data !== 9'd0 || cyc != 1) begin
            errors++;
            $display("FAIL midreset_restart got v=%b d=%0d cycles=%0d exp v=1 d=0 cycles=1",
                     if1.src_vaild, if1.src_data, cyc);
        end
        cyc = 0;
        while (if1.dst_done !== 1'b1 && cyc < 3000) begin
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (if1.dst_done !== 1'b1 || if1.rx_count !== 9'd256 || if1.err !== 1'b0 || if1.err_count !== 9'd0) begin
            errors++;
            $display("FAIL midreset_rerun got done=%b rx=%0d e=%b ec=%0d exp 1 256 0 0",
                     if1.dst_done, if1.rx_count, if1.err, if1.err_count);
        end
    endtask

    initial begin
        test_reset();
        test_loopback_full();
        test_backpressure();
        test_start_toggle();
        test_corrupt();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
